// File: rtl/clk_pkg.sv
// -----------------------------------------------------------------------------
// clk_pkg
// Shared definitions for the clock-enable scheduler:
//   - DIV_W_DEF   : default divisor width
//   - cfg_state_t : configuration FSM state encoding
//   - ch_idx_w()  : channel-index width, never narrower than 1 bit
// -----------------------------------------------------------------------------
package clk_pkg;

    localparam int unsigned DIV_W_DEF = 16;

    typedef enum logic [0:0] {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_en_counter.sv
// -----------------------------------------------------------------------------
// clk_en_counter
// One tick channel: free-running modulo counter that emits a registered
// single-cycle enable pulse at the end of every period of max(div,1) cycles.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       commit new div/en this edge (also restarts the period)
//   load_div_i   new divisor (0 behaves as 1)
//   load_en_i    new enable state
//   tick_o       registered enable pulse
//   term_o       combinational: channel enabled and in last cycle of period
//   en_o         current enable state
// -----------------------------------------------------------------------------
module clk_en_counter
    import clk_pkg::*;
#(
    parameter int unsigned DIV_W     = DIV_W_DEF,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_div_i,
    input  logic             load_en_i,
    output logic             tick_o,
    output logic             term_o,
    output logic             en_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] last_cnt;

    // A stored divisor of 0 behaves as 1, so its terminal count is 0.
    assign last_cnt = (div_q == '0) ? '0 : div_q - 1'b1;
    assign term_o   = en_q && (cnt_q == last_cnt);
    assign tick_o   = tick_q;
    assign en_o     = en_q;

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        en_d   = en_q;
        tick_d = 1'b0;
        if (en_q) begin
            if (cnt_q == last_cnt) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A load keeps tick_d untouched so the old period's terminal tick
        // still fires on the commit edge.
        if (load_i) begin
            div_d = load_div_i;
            en_d  = load_en_i;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= DIV_W'(RESET_DIV);
            en_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            en_q   <= en_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/clk_en_scheduler.sv
// -----------------------------------------------------------------------------
// clk_en_scheduler
// NUM_CH independent clock-enable tick generators with runtime-programmable
// periods. A single-entry valid/ready config port reprograms one channel; the
// change commits only on that channel's period boundary (or at once when the
// channel is disabled), so no runt or stretched periods are produced.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   cfg_valid   config request valid
//   cfg_ready   request can be accepted (only in IDLE)
//   cfg_ch      target channel
//   cfg_div     new period in cycles (0 treated as 1)
//   cfg_en      new enable state
//   cfg_err     1-cycle pulse: accepted request named a nonexistent channel
//   busy        request accepted, waiting to commit
//   tick        per-channel registered enable pulses
// -----------------------------------------------------------------------------
module clk_en_scheduler
    import clk_pkg::*;
#(
    parameter  int unsigned NUM_CH    = 4,
    parameter  int unsigned DIV_W     = DIV_W_DEF,
    parameter  int unsigned RESET_DIV = 2,
    localparam int unsigned CH_W      = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic              cfg_err,
    output logic              busy,
    output logic [NUM_CH-1:0] tick
);

    cfg_state_t        state_q, state_d;
    logic [CH_W-1:0]   req_ch_q, req_ch_d;
    logic [DIV_W-1:0]  req_div_q, req_div_d;
    logic              req_en_q, req_en_d;
    logic              err_q, err_d;

    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] term;
    logic [NUM_CH-1:0] ch_en;
    logic              ch_bad;

    // Extra leading bit lets NUM_CH itself be represented for the compare.
    assign ch_bad  = {1'b0, cfg_ch} >= NUM_CH[CH_W:0];
    assign cfg_err = err_q;

    always_comb begin
        state_d   = state_q;
        req_ch_d  = req_ch_q;
        req_div_d = req_div_q;
        req_en_d  = req_en_q;
        err_d     = 1'b0;
        load      = '0;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            CFG_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (ch_bad) begin
                        err_d = 1'b1;
                    end else begin
                        req_ch_d  = cfg_ch;
                        req_div_d = cfg_div;
                        req_en_d  = cfg_en;
                        state_d   = CFG_PEND;
                    end
                end
            end
            CFG_PEND: begin
                busy = 1'b1;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if ((req_ch_q == CH_W'(i)) && (!ch_en[i] || term[i])) begin
                        load[i] = 1'b1;
                        state_d = CFG_IDLE;
                    end
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CFG_IDLE;
            req_ch_q  <= '0;
            req_div_q <= '0;
            req_en_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_ch_q  <= req_ch_d;
            req_div_q <= req_div_d;
            req_en_q  <= req_en_d;
            err_q     <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_en_counter #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (load[g]),
            .load_div_i (req_div_q),
            .load_en_i  (req_en_q),
            .tick_o     (tick[g]),
            .term_o     (term[g]),
            .en_o       (ch_en[g])
        );
    end

endmodule

// File: tb/tb_clk_en_scheduler.sv
// -----------------------------------------------------------------------------
// tb_clk_en_scheduler
// Directed bench for clk_en_scheduler with NUM_CH=3 (so cfg_ch=3 is the
// out-of-range channel encoding on the 2-bit channel field).
// -----------------------------------------------------------------------------
module tb_clk_en_scheduler;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_en;
    logic        cfg_err;
    logic        busy;
    logic [2:0]  tick;

    int checks = 0;
    int errors = 0;

    clk_en_scheduler #(
        .NUM_CH    (3),
        .DIV_W     (16),
        .RESET_DIV (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge (IDLE guarantees acceptance).
    task automatic cfg(input logic [1:0] ch, input logic [15:0] d, input logic e);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = d;
        cfg_en    = e;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        // ---- 1: reset state and idle run ----
        chk("rst_tick",  32'(tick),      32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_err",   32'(cfg_err),   32'd0);
        #20 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("idle_tick",  32'(tick),      32'd0);
            chk("idle_ready", 32'(cfg_ready), 32'd1);
            chk("idle_busy",  32'(busy),      32'd0);
        end

        // ---- 2: ch0 div=4 enable, then disable on running channel ----
        cfg(2'd0, 16'd4, 1'b1);
        chk("s2_busy_pend",  32'(busy),      32'd1);
        chk("s2_ready_pend", 32'(cfg_ready), 32'd0);
        step();
        chk("s2_busy_commit", 32'(busy), 32'd0);
        chk("s2_tick_commit", 32'(tick), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("s2_tick", 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
        end
        cfg(2'd0, 16'd4, 1'b0);          // cnt now 1
        chk("s2d_busy0", 32'(busy), 32'd1);
        chk("s2d_tick0", 32'(tick), 32'd0);
        step();
        chk("s2d_busy1", 32'(busy), 32'd1);
        step();
        chk("s2d_busy2", 32'(busy), 32'd1);
        chk("s2d_tick2", 32'(tick), 32'd0);
        step();
        chk("s2d_busy3",  32'(busy), 32'd0);
        chk("s2d_final",  32'(tick), 32'd1);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("s2d_silent", 32'(tick), 32'd0);
        end

        // ---- 3: ch1 div=10 reprogrammed to div=3 mid-period ----
        cfg(2'd1, 16'd10, 1'b1);
        step();                          // commit edge E, cnt=0
        chk("s3_busy_commit", 32'(busy), 32'd0);
        step();
        step();                          // cnt=2
        chk("s3_tick_pre", 32'(tick), 32'd0);
        cfg(2'd1, 16'd3, 1'b1);          // accepted, cnt=3
        chk("s3_busy_acc", 32'(busy), 32'd1);
        // Hammer cfg_valid while pending: must be ignored.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd2;
        cfg_en    = 1'b1;
        for (int k = 4; k <= 9; k++) begin
            step();
            chk("s3_busy_wait",  32'(busy),      32'd1);
            chk("s3_ready_wait", 32'(cfg_ready), 32'd0);
            chk("s3_tick_wait",  32'(tick),      32'd0);
        end
        cfg_valid = 1'b0;
        step();                          // old terminal count: commit
        chk("s3_busy_done", 32'(busy), 32'd0);
        chk("s3_old_tick",  32'(tick), 32'd2);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("s3_new_tick", 32'(tick), (k % 3 == 0) ? 32'd2 : 32'd0);
        end

        // ---- 4: ch2 div=0 and div=1 run continuously, then disable ----
        cfg(2'd2, 16'd0, 1'b1);
        chk("s4_busy0", 32'(busy),    32'd1);
        chk("s4_t0",    32'(tick[2]), 32'd0);
        step();
        chk("s4_busy0c", 32'(busy),    32'd0);
        chk("s4_t0c",    32'(tick[2]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("s4_div0_high", 32'(tick[2]), 32'd1);
        end
        cfg(2'd2, 16'd1, 1'b1);
        chk("s4_busy1", 32'(busy),    32'd1);
        chk("s4_t1",    32'(tick[2]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s4_div1_high", 32'(tick[2]), 32'd1);
        end
        chk("s4_busy1c", 32'(busy), 32'd0);
        cfg(2'd2, 16'd1, 1'b0);
        chk("s4_dis_busy", 32'(busy),    32'd1);
        chk("s4_dis_t0",   32'(tick[2]), 32'd1);
        step();
        chk("s4_dis_done", 32'(busy),    32'd0);
        chk("s4_dis_last", 32'(tick[2]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s4_dis_low", 32'(tick[2]), 32'd0);
        end

        // ---- 5: out-of-range channel ----
        cfg(2'd3, 16'd7, 1'b1);
        chk("s5_err",   32'(cfg_err),   32'd1);
        chk("s5_busy",  32'(busy),      32'd0);
        chk("s5_ready", 32'(cfg_ready), 32'd1);
        step();
        chk("s5_err_clr", 32'(cfg_err), 32'd0);
        chk("s5_busy2",   32'(busy),    32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("s5_ch0", 32'(tick[0]), 32'd0);
            chk("s5_ch2", 32'(tick[2]), 32'd0);
        end

        // ---- 6: reset during PEND with ch1 mid-period ----
        cfg(2'd1, 16'd5, 1'b1);
        chk("s6_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("s6_rst_tick",  32'(tick),      32'd0);
        chk("s6_rst_busy",  32'(busy),      32'd0);
        chk("s6_rst_ready", 32'(cfg_ready), 32'd1);
        chk("s6_rst_err",   32'(cfg_err),   32'd0);
        #20 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("s6_idle_tick",  32'(tick),      32'd0);
            chk("s6_idle_ready", 32'(cfg_ready), 32'd1);
            chk("s6_idle_busy",  32'(busy),      32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
